// File: rtl/vera_bus_pkg.sv
// Shared types and constants for the VERA CPU-side register port.
package vera_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD
    } state_t;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_AW,
        EV_DW,
        EV_DR
    } event_t;

    localparam logic        REG_ADDR      = 1'b0;
    localparam logic        REG_DATA      = 1'b1;
    localparam logic [11:0] VERA_ADDR_REG = 12'h9F2;
    localparam logic [11:0] VERA_DATA_REG = 12'h9F3;

endpackage

// File: rtl/vera_bus_strobe_sync.sv
// Two-flop synchronizer for an asynchronous active-low CPU strobe, with
// rise/fall detection against one extra history flop.
module strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_i,
    output logic level_o,
    output logic fall_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic last_q;

    // Reset to the idle (high) level so reset release never looks like a strobe edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            last_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make this a true 3-stage shift chain;
            // blocking ones would collapse it into a single flop.
            meta_q <= strobe_i;
            sync_q <= meta_q;
            last_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = last_q & ~sync_q;
    assign rise_o  = ~last_q & sync_q;

endmodule

// File: rtl/vera_bus_responder.sv
// Two-register VERA port: address pointer at 0x9F2 and an auto-incrementing
// prefetched data port at 0x9F3, driving a req/ack video-memory port.
module vera_bus_responder
    import vera_bus_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rdB,
    input  logic          wrB,
    input  logic          reg_sel,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          err
);

    logic rd_lvl, rd_fall, rd_rise;
    logic wr_lvl, wr_fall, wr_rise;

    strobe_sync u_rd_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .strobe_i(rdB),
        .level_o (rd_lvl),
        .fall_o  (rd_fall),
        .rise_o  (rd_rise)
    );

    strobe_sync u_wr_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .strobe_i(wrB),
        .level_o (wr_lvl),
        .fall_o  (wr_fall),
        .rise_o  (wr_rise)
    );

    state_t        state_q, state_d;
    logic          busy_q;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] pref_q, pref_d;
    logic          pend_valid_q, pend_valid_d;
    event_t        pend_ev_q, pend_ev_d;
    logic [DW-1:0] pend_data_q, pend_data_d;
    logic          err_q, err_d;
    logic          rd_sel_q, rd_sel_d;
    logic          rd_armed_q, rd_armed_d;

    logic          conflict;
    event_t        new_ev, exec_ev;
    logic [DW-1:0] new_data, exec_data;

    assign conflict = ~rd_lvl & ~wr_lvl;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        ptr_d        = ptr_q;
        wdata_d      = wdata_q;
        pref_d       = pref_q;
        pend_valid_d = pend_valid_q;
        pend_ev_d    = pend_ev_q;
        pend_data_d  = pend_data_q;
        err_d        = err_q;
        rd_sel_d     = rd_sel_q;
        rd_armed_d   = rd_armed_q;
        new_ev       = EV_NONE;
        new_data     = '0;
        exec_ev      = EV_NONE;
        exec_data    = '0;

        // A read only counts if its falling edge was accepted, so an overlap
        // with a write cannot later turn into a spurious data-read event.
        if (conflict) begin
            err_d      = 1'b1;
            rd_armed_d = 1'b0;
        end else begin
            if (rd_fall) begin
                rd_sel_d   = reg_sel;
                rd_armed_d = 1'b1;
            end
            if (rd_rise && rd_armed_q) begin
                rd_armed_d = 1'b0;
                if (rd_sel_q == REG_DATA) new_ev = EV_DR;
            end
            if (wr_fall) begin
                if (new_ev != EV_NONE) err_d = 1'b1;
                new_ev   = (reg_sel == REG_DATA) ? EV_DW : EV_AW;
                new_data = din;
            end
        end

        // Pending work runs first on return to IDLE; a new arrival takes its slot.
        if (state_q == IDLE) begin
            if (pend_valid_q) begin
                exec_ev      = pend_ev_q;
                exec_data    = pend_data_q;
                pend_valid_d = 1'b0;
                if (new_ev != EV_NONE) begin
                    pend_valid_d = 1'b1;
                    pend_ev_d    = new_ev;
                    pend_data_d  = new_data;
                end
            end else begin
                exec_ev   = new_ev;
                exec_data = new_data;
            end
        end else if (new_ev != EV_NONE) begin
            if (pend_valid_q) begin
                err_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_ev_d    = new_ev;
                pend_data_d  = new_data;
            end
        end

        case (state_q)
            IDLE: begin
                case (exec_ev)
                    EV_AW: begin
                        ptr_d   = exec_data[AW-1:0];
                        state_d = RD;
                    end
                    EV_DW: begin
                        wdata_d = exec_data;
                        state_d = WR;
                    end
                    EV_DR: begin
                        ptr_d   = ptr_q + AW'(1);
                        state_d = RD;
                    end
                    default: ;
                endcase
            end
            WR: begin
                if (mem_ack) begin
                    ptr_d   = ptr_q + AW'(1);
                    state_d = RD;
                end
            end
            RD: begin
                if (mem_ack) begin
                    pref_d  = mem_rdata;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            ptr_q        <= '0;
            wdata_q      <= '0;
            pref_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_ev_q    <= EV_NONE;
            pend_data_q  <= '0;
            err_q        <= 1'b0;
            rd_sel_q     <= REG_ADDR;
            rd_armed_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= (state_d != IDLE);
            ptr_q        <= ptr_d;
            wdata_q      <= wdata_d;
            pref_q       <= pref_d;
            pend_valid_q <= pend_valid_d;
            pend_ev_q    <= pend_ev_d;
            pend_data_q  <= pend_data_d;
            err_q        <= err_d;
            rd_sel_q     <= rd_sel_d;
            rd_armed_q   <= rd_armed_d;
        end
    end

    // Request fields come straight from state and registers, so they hold still until ack.
    assign mem_req   = (state_q != IDLE);
    assign mem_we    = (state_q == WR);
    assign mem_addr  = ptr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign dout      = (reg_sel == REG_DATA) ? pref_q : DW'(ptr_q);

endmodule

// File: tb/tb_vera_bus_responder.sv
// Scoreboard bench: a CPU-level model predicts memory requests and read data;
// a memory responder answers requests and a monitor checks each handshake.
module tb_vera_bus_responder;

    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rdB, wrB, reg_sel;
    logic [DW-1:0] din, dout;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy, err;

    vera_bus_responder #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rdB      (rdB),
        .wrB      (wrB),
        .reg_sel  (reg_sel),
        .din      (din),
        .dout     (dout),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } req_t;

    req_t        exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          stall = 0;
    bit          resp_en = 1'b1;
    int          req_count = 0;
    logic [15:0] bus_mem [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] ref_ptr = '0;

    function automatic logic [15:0] dflt(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] bus_read(input logic [15:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: each CPU access expressed as the requests it must cause.
    task automatic push_prefetch();
        exp_q.push_back('{we: 1'b0, addr: ref_ptr, data: 16'h0});
    endtask

    task automatic model_aw(input logic [15:0] d);
        ref_ptr = d;
        push_prefetch();
    endtask

    task automatic model_dw(input logic [15:0] d);
        exp_q.push_back('{we: 1'b1, addr: ref_ptr, data: d});
        ref_mem[ref_ptr] = d;
        ref_ptr = ref_ptr + 16'd1;
        push_prefetch();
    endtask

    task automatic model_dr();
        ref_ptr = ref_ptr + 16'd1;
        push_prefetch();
    endtask

    task automatic cpu_write(input logic sel, input logic [15:0] d, input bit modelled);
        reg_sel = sel;
        din     = d;
        wrB     = 1'b0;
        if (modelled) begin
            if (sel) model_dw(d);
            else     model_aw(d);
        end
        repeat (6) @(negedge clk);
        wrB = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic cpu_read(input logic sel);
        reg_sel = sel;
        rdB     = 1'b0;
        repeat (6) @(negedge clk);
        if (sel) check("dout_data", dout, ref_read(ref_ptr));
        else     check("dout_addr", dout, ref_ptr);
        rdB = 1'b1;
        if (sel) model_dr();
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (i >= 4 && !busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b outstanding=%0d", busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Memory responder: acks after 'stall' cycles, one-cycle ack pulse.
    initial begin
        int cnt = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                cnt = 0;
            end else if (!rst_n) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (mem_req) begin
                if (cnt >= stall) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        bus_mem[mem_addr] = mem_wdata;
                        mem_rdata = 16'hDEAD;
                    end else begin
                        mem_rdata = bus_read(mem_addr);
                    end
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Monitor: every completed handshake must match the head of the scoreboard.
    initial begin
        req_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && mem_req && mem_ack) begin
                req_count++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_req: we=%0b addr=%h got a request, required none",
                             mem_we, mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("req_we", mem_we, e.we);
                    check("req_addr", mem_addr, e.addr);
                    if (e.we) check("req_wdata", mem_wdata, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        bit seen;
        rst_n   = 1'b0;
        rdB     = 1'b1;
        wrB     = 1'b1;
        reg_sel = 1'b0;
        din     = '0;
        bus_mem[16'h1234] = 16'hBEEF;
        ref_mem[16'h1234] = 16'hBEEF;

        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_dout_ptr", dout, 0);
        reg_sel = 1'b1;
        #1 check("rst_dout_pref", dout, 0);
        reg_sel = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Address write, then data read of the prefetched word.
        cpu_write(1'b0, 16'h1234, 1'b1);
        wait_idle();
        cpu_read(1'b1);
        wait_idle();

        // Two data writes from 0x0010.
        cpu_write(1'b0, 16'h0010, 1'b1);
        wait_idle();
        cpu_write(1'b1, 16'hAAAA, 1'b1);
        wait_idle();
        cpu_write(1'b1, 16'h5555, 1'b1);
        wait_idle();
        cpu_read(1'b0);

        // Pointer wrap.
        cpu_write(1'b0, 16'hFFFF, 1'b1);
        wait_idle();
        cpu_read(1'b1);
        wait_idle();
        cpu_read(1'b0);
        check("wrap_err", err, 0);

        // Stalled memory: second write pends, third is dropped.
        stall = 20;
        cpu_write(1'b1, 16'h1111, 1'b1);
        cpu_write(1'b1, 16'h2222, 1'b1);
        cpu_write(1'b1, 16'h3333, 1'b0);
        wait_idle();
        check("overflow_err", err, 1);
        cpu_read(1'b0);

        // Reset during an outstanding request.
        cpu_write(1'b0, 16'h0040, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("req_before_reset", seen, 1);
        resp_en = 1'b0;
        mem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", mem_req, 0);
        check("async_rst_we", mem_we, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_err", err, 0);
        check("async_rst_addr", mem_addr, 0);
        check("async_rst_dout", dout, 0);
        exp_q.delete();
        ref_ptr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 16'h7777;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("stale_ack_req", mem_req, 0);
        check("stale_ack_busy", busy, 0);
        reg_sel = 1'b1;
        #1 check("stale_ack_pref", dout, 0);
        reg_sel = 1'b0;
        #1 check("stale_ack_ptr", dout, 0);
        stall   = 0;
        resp_en = 1'b1;

        // Simultaneous read and write strobes.
        saved   = req_count;
        reg_sel = 1'b1;
        rdB     = 1'b0;
        wrB     = 1'b0;
        repeat (6) @(negedge clk);
        rdB = 1'b1;
        wrB = 1'b1;
        repeat (10) @(negedge clk);
        check("conflict_err", err, 1);
        check("conflict_no_req", req_count, saved);
        check("conflict_busy", busy, 0);
        reg_sel = 1'b0;
        #1 check("conflict_ptr", dout, 0);

        // Randomized accesses with random memory latency.
        for (int i = 0; i < 40; i++) begin
            int op;
            logic [15:0] v;
            stall = $urandom_range(0, 3);
            op    = (i == 0) ? 0 : $urandom_range(0, 3);
            v     = 16'($urandom);
            case (op)
                0: begin
                    if ($urandom_range(0, 3) == 0) v = 16'hFFFE + 16'($urandom_range(0, 1));
                    cpu_write(1'b0, v, 1'b1);
                end
                1: cpu_write(1'b1, v, 1'b1);
                2: cpu_read(1'b1);
                default: cpu_read(1'b0);
            endcase
            wait_idle();
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vera_bus_responder.md
# vera_bus_responder

Responder end of the CPU→VERA strobe interface: receives the active-low `rdB`/`wrB` strobes and register select produced by the bus-decode CPLD and implements the two-register VERA port. Register 0x9F2 (`reg_sel`=0) is the VRAM address pointer. Register 0x9F3 (`reg_sel`=1) is an auto-incrementing data port backed by a prefetch latch. The block sits in the video FPGA between the CPLD strobes and the video-memory request/ack port.

## Interface
Parameters:
- `DW`, 16, CPU data width and VRAM word width
- `AW`, 16, VRAM address width, AW ≤ DW

Ports:
- `clk`  in  1  video-domain clock
- `rst_n`  in  1  asynchronous, active-low reset
- `rdB`  in  1  active-low read strobe from CPLD, asynchronous to `clk`
- `wrB`  in  1  active-low write strobe from CPLD, asynchronous to `clk`
- `reg_sel`  in  1  CPU adr[0]: 0 = address reg (0x9F2), 1 = data port (0x9F3)
- `din`  in  DW  CPU write data, stable while strobe low
- `dout`  out  DW  CPU read data; `reg_sel`=0 → zero-extended pointer, 1 → prefetch latch
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`  out  1  1 = write, 0 = read; valid with `mem_req`
- `mem_addr`  out  AW  memory address, always equals pointer
- `mem_wdata`  out  DW  write data
- `mem_ack`  in  1  single-cycle completion
- `mem_rdata`  in  DW  read data, valid with `mem_ack`
- `busy`  out  1  FSM not in IDLE
- `err`  out  1  sticky error flag, cleared only by reset

## Operation
- Each strobe passes through a 2-flop synchronizer plus edge detector. The block reacts to these edges:
  - `wrB` fall: capture `din` and `reg_sel`.
  - `rdB` fall: latch `reg_sel`.
  - `rdB` rise: act on the latched `reg_sel`.
- Events:
  - AW (address write): pointer ← `din[AW-1:0]`, then prefetch.
  - DW (data write): wdata ← `din`, memory write, pointer+1, then prefetch.
  - DR (data read end, `rdB` rise with latched sel=1): pointer+1, then prefetch.
  - Address-register reads cause no action.
- FSM states:
  - IDLE: on AW → RD; on DW → WR; on DR → pointer+1, then RD.
  - WR: `mem_req`=1, `mem_we`=1. On `mem_ack`: pointer+1 → RD.
  - RD: `mem_req`=1, `mem_we`=0. On `mem_ack`: prefetch latch ← `mem_rdata` → IDLE.
- `dout` is a combinational mux on the raw `reg_sel`. The prefetch latch changes only after `rdB` rise, so the CPU always sees a stable value.
- Pointer arithmetic is modulo 2^AW: 0xFFFF+1 = 0x0000, no flag.
- Event arriving while `busy`: stored in a one-entry pending slot and executed on return to IDLE.
  - A second event while the slot is full is dropped and sets `err`.
- `rdB` and `wrB` both synchronized-low in the same cycle: both ignored, `err` set.
- Reset values: pointer 0, prefetch latch 0, `mem_req`=0, `mem_we`=0, `busy`=0, `err`=0, pending empty, state IDLE.
  - Reset mid-request drops `mem_req` immediately. An in-flight `mem_ack` arriving after reset release is ignored.

## Timing
- Strobe edge at raw input → event visible internally 3 `clk` later: 2 sync flops + edge register.
- CPU strobe low time ≥ 4 `clk`. `din` stable from strobe fall to strobe rise.
- `mem_req` asserts the cycle after the event is visible.
  - Zero-wait memory (ack in the cycle after req): DW completes write + prefetch in 4 cycles after the event.
  - Zero-wait memory: AW and DR complete their prefetch in 2 cycles after the event.
- `mem_addr`, `mem_we` and `mem_wdata` are held constant while `mem_req`=1.
- `busy` is registered and equals (state ≠ IDLE).

## Structure
- Package `vera_bus_pkg` holds:
  - state enum {IDLE, WR, RD}
  - event enum {EV_NONE, EV_AW, EV_DW, EV_DR}
  - constants REG_ADDR=0, REG_DATA=1, VERA_ADDR_REG=12'h9F2, VERA_DATA_REG=12'h9F3
- Sub-module `strobe_sync`: 2-flop synchronizer plus rise/fall edge detect, async active-low reset to the deasserted (high) level. Instanced once for `rdB` and once for `wrB`.

## Test plan
- Write 0x1234 to addr reg → one read request at 0x1234. With `mem_rdata`=0xBEEF, a following data read returns `dout`=0xBEEF; the next request is at 0x1235.
- Pointer 0x0010, write 0xAAAA and then 0x5555 to the data port → writes at 0x0010 and 0x0011, final pointer 0x0012, prefetch request at 0x0012.
- Pointer 0xFFFF, one data read → pointer wraps to 0x0000 and the next prefetch request is at 0x0000; `err`=0.
- Memory ack stalled 20 cycles, two data writes issued back-to-back → second write is held in pending and executed; a third write during the stall sets `err`=1.
- Assert `rst_n` low while `mem_req`=1 → all outputs return to reset values asynchronously; a stale `mem_ack` after release causes no state change.
- `rdB` and `wrB` driven low together → no memory request; `err`=1.
